// File: rtl/ev_ts_pkg.sv
// Shared types for the event-timestamp record path: the record struct, frame constants
// and the serializer FSM encoding.
package ev_ts_pkg;

    // Records are carried at maximum legal widths; narrower instances zero-extend.
    localparam int REC_ID_W = 8;
    localparam int REC_TS_W = 32;

    localparam logic [7:0] SOF_BYTE = 8'hA5;

    typedef struct packed {
        logic [REC_ID_W-1:0] id;
        logic [REC_TS_W-1:0] start_ts;
        logic [REC_TS_W-1:0] end_ts;
        logic [REC_TS_W-1:0] delta;
    } ts_rec_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    function automatic int ts_bytes(input int ts_w);
        return (ts_w + 7) / 8;
    endfunction

endpackage

// File: rtl/ts_rec_fifo.sv
// Synchronous record FIFO. ready and level are registered, so a push can never race a
// pop into a full FIFO and a record is never visible to the reader in its push cycle.
module ts_rec_fifo
    import ev_ts_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  ts_rec_t          push_rec,
    output logic             ready,
    input  logic             pop,
    output ts_rec_t          pop_rec,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    ts_rec_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             ready_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && ready_q;
    assign do_pop  = pop && (level_q != '0);

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ready_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level_q <= level_d;
            ready_q <= (level_d != LVL_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_rec;
    end

    assign pop_rec = mem[rd_ptr];
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign ready   = ready_q;

endmodule

// File: rtl/ev_ts_record_serializer.sv
// Buffers timestamp records and emits each as a framed, big-endian byte stream:
// SOF, seq, id, start_ts, end_ts, delta, with m_last on the final delta byte.
module ev_ts_record_serializer
    import ev_ts_pkg::*;
#(
    parameter int ID_W       = 3,
    parameter int TS_W       = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ID_W-1:0]  in_id,
    input  logic [TS_W-1:0]  in_start_ts,
    input  logic [TS_W-1:0]  in_end_ts,
    input  logic [TS_W-1:0]  in_delta,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int TSB       = ts_bytes(TS_W);
    localparam int REC_BYTES = 3 + 3 * TSB;
    localparam int IDX_W     = $clog2(REC_BYTES);

    ts_rec_t          rec_in;
    ts_rec_t          rec_out;
    ts_rec_t          frame_q;
    logic             fifo_empty;
    logic             load;
    ser_state_e       state_q;
    ser_state_e       state_d;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       seq_q;
    logic [7:0]       frame_seq_q;
    logic             last_idx;
    logic             byte_acc;
    logic [7:0]       byte_c;
    logic [REC_TS_W-1:0] fld [3];

    always_comb begin
        rec_in                      = '0;
        rec_in.id[ID_W-1:0]         = in_id;
        rec_in.start_ts[TS_W-1:0]   = in_start_ts;
        rec_in.end_ts[TS_W-1:0]     = in_end_ts;
        rec_in.delta[TS_W-1:0]      = in_delta;
    end

    ts_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (in_valid),
        .push_rec (rec_in),
        .ready    (in_ready),
        .pop      (load),
        .pop_rec  (rec_out),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign last_idx = (idx_q == IDX_W'(REC_BYTES - 1));
    assign byte_acc = (state_q == SEND) && m_ready;

    // Loading on the last accepted byte keeps consecutive frames gap-free.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (byte_acc && last_idx) begin
                    if (!fifo_empty) load = 1'b1;
                    else             state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            seq_q       <= 8'd0;
            frame_seq_q <= 8'd0;
            frame_q     <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                frame_q     <= rec_out;
                frame_seq_q <= seq_q;
                seq_q       <= seq_q + 8'd1;
                idx_q       <= '0;
            end else if (byte_acc) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    function automatic logic [7:0] field_byte(input logic [REC_TS_W-1:0] v, input int k);
        return v[8*k +: 8];
    endfunction

    always_comb begin
        byte_c = 8'h00;
        fld[0] = frame_q.start_ts;
        fld[1] = frame_q.end_ts;
        fld[2] = frame_q.delta;
        case (int'(idx_q))
            0:       byte_c = SOF_BYTE;
            1:       byte_c = frame_seq_q;
            2:       byte_c = frame_q.id;
            default: begin
                for (int f = 0; f < 3; f++) begin
                    for (int j = 0; j < TSB; j++) begin
                        if (int'(idx_q) == 3 + f * TSB + j) byte_c = field_byte(fld[f], TSB - 1 - j);
                    end
                end
            end
        endcase
    end

    assign m_valid = (state_q == SEND);
    assign m_data  = m_valid ? byte_c : 8'h00;
    assign m_last  = m_valid && last_idx;

endmodule

// File: tb/tb_ev_ts_record_serializer.sv
// Bench for ev_ts_record_serializer: a TS_W=8 instance for the main scenarios and a
// TS_W=12 instance for multi-byte timestamp fields.
module tb_ev_ts_record_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_id;
    logic [7:0] in_start_ts;
    logic [7:0] in_end_ts;
    logic [7:0] in_delta;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic [2:0] fifo_level;

    logic        in12_valid;
    logic        in12_ready;
    logic [2:0]  in12_id;
    logic [11:0] in12_start_ts;
    logic [11:0] in12_end_ts;
    logic [11:0] in12_delta;
    logic        m12_valid;
    logic        m12_ready;
    logic [7:0]  m12_data;
    logic        m12_last;
    logic [2:0]  fifo12_level;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] exp12_q[$];
    logic [7:0] exp_seq;

    ev_ts_record_serializer #(.ID_W(3), .TS_W(8), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_id       (in_id),
        .in_start_ts (in_start_ts),
        .in_end_ts   (in_end_ts),
        .in_delta    (in_delta),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .fifo_level  (fifo_level)
    );

    ev_ts_record_serializer #(.ID_W(3), .TS_W(12), .FIFO_DEPTH(4)) dut12 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in12_valid),
        .in_ready    (in12_ready),
        .in_id       (in12_id),
        .in_start_ts (in12_start_ts),
        .in_end_ts   (in12_end_ts),
        .in_delta    (in12_delta),
        .m_valid     (m12_valid),
        .m_ready     (m12_ready),
        .m_data      (m12_data),
        .m_last      (m12_last),
        .fifo_level  (fifo12_level)
    );

    // Scoreboard: inputs change just after posedge, so a byte seen valid&ready at negedge
    // is the byte accepted on the following posedge.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && m_valid && m_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL byte8_unexpected: got last=%b data=%h, expected no byte", m_last, m_data);
            end else begin
                e = exp_q.pop_front();
                if ({m_last, m_data} !== e)
                    $display("FAIL byte8: got last=%b data=%h, expected last=%b data=%h", m_last, m_data, e[8], e[7:0]);
                else
                    n_pass++;
            end
        end
        if (rst_n && m12_valid && m12_ready) begin
            n_checks++;
            if (exp12_q.size() == 0) begin
                $display("FAIL byte12_unexpected: got last=%b data=%h, expected no byte", m12_last, m12_data);
            end else begin
                e = exp12_q.pop_front();
                if ({m12_last, m12_data} !== e)
                    $display("FAIL byte12: got last=%b data=%h, expected last=%b data=%h", m12_last, m12_data, e[8], e[7:0]);
                else
                    n_pass++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        in12_valid = 1'b0;
        exp_q.delete();
        exp12_q.delete();
        exp_seq = 8'd0;
        idle(2);
        #1 rst_n = 1'b1;
        idle(1);
    endtask

    // Holds the record until accepted; called just after a posedge, returns just after one.
    task automatic push_rec(input logic [2:0] id, input logic [7:0] s, input logic [7:0] e,
                            input logic [7:0] d);
        int  waited;
        bit  ok;
        waited = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_id = id;
        in_start_ts = s;
        in_end_ts = e;
        in_delta = d;
        while (!ok && waited < 2000) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            $display("FAIL push_timeout: got in_ready=0 for %0d cycles, expected acceptance", waited);
        end else begin
            n_pass++;
            exp_q.push_back({1'b0, 8'hA5});
            exp_q.push_back({1'b0, exp_seq});
            exp_q.push_back({1'b0, 5'd0, id});
            exp_q.push_back({1'b0, s});
            exp_q.push_back({1'b0, e});
            exp_q.push_back({1'b1, d});
            exp_seq = exp_seq + 8'd1;
        end
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: got %0d bytes still pending, expected 0", name, exp_q.size());
        else
            n_pass++;
        idle(8);
    endtask

    task automatic wait_m_valid(input string name);
        int c;
        c = 0;
        while (!m_valid && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        n_checks++;
        if (m_valid !== 1'b1) $display("FAIL %s_m_valid: got %b, expected 1", name, m_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #12;
        n_checks++;
        if ({in_ready, m_valid, m_last, m_data, fifo_level} !== 14'd0)
            $display("FAIL reset_outputs: got in_ready=%b m_valid=%b m_last=%b m_data=%h level=%0d, expected all 0",
                     in_ready, m_valid, m_last, m_data, fifo_level);
        else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_ready_before_edge: got %b, expected 0", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready_after_edge: got %b, expected 1", in_ready);
        else n_pass++;
        exp_q.delete();
        exp_seq = 8'd0;
    endtask

    task automatic test_single();
        m_ready = 1'b1;
        push_rec(3'd3, 8'd10, 8'd15, 8'd5);
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b0) $display("FAIL single_latency_early: got m_valid=%b, expected 0", m_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5)
            $display("FAIL single_latency_sof: got m_valid=%b data=%h, expected 1 a5", m_valid, m_data);
        else n_pass++;
        @(posedge clk);
        #1;
        drain("single");
    endtask

    task automatic test_wrap_delta();
        m_ready = 1'b1;
        push_rec(3'd6, 8'd250, 8'd4, 8'd10);
        drain("wrap_delta");
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        push_rec(3'd2, 8'h33, 8'h44, 8'h11);
        wait_m_valid("bp");
        m_ready = 1'b1;
        idle(3);
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== 8'h33 || m_last !== 1'b0)
                $display("FAIL bp_stall%0d: got valid=%b data=%h last=%b, expected 1 33 0", i, m_valid, m_data, m_last);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain("bp");
    endtask

    task automatic test_full_back_to_back();
        int got;
        int gaps;
        int c;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_rec(3'(i), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            if (i == 3) begin
                n_checks++;
                if (in_ready !== 1'b1 || fifo_level !== 3'd3)
                    $display("FAIL full_after4: got in_ready=%b level=%0d, expected 1 3", in_ready, fifo_level);
                else n_pass++;
            end
            if (i == 4) begin
                n_checks++;
                if (in_ready !== 1'b0 || fifo_level !== 3'd4)
                    $display("FAIL full_after5: got in_ready=%b level=%0d, expected 0 4", in_ready, fifo_level);
                else n_pass++;
            end
        end
        idle(2);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL full_hold: got in_ready=%b, expected 0", in_ready);
        else n_pass++;
        m_ready = 1'b1;
        got = 0;
        gaps = 0;
        c = 0;
        while (got < 30 && c < 200) begin
            @(negedge clk);
            c++;
            if (m_valid) got++;
            else gaps++;
        end
        n_checks++;
        if (got != 30 || gaps != 0)
            $display("FAIL b2b_stream: got %0d bytes with %0d idle cycles, expected 30 with 0", got, gaps);
        else n_pass++;
        @(posedge clk);
        #1;
        drain("full");
    endtask

    task automatic test_seq_wrap();
        apply_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 257; i++)
            push_rec(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)));
        n_checks++;
        if (exp_seq !== 8'd1) $display("FAIL seq_model: got next seq %h, expected 01", exp_seq);
        else n_pass++;
        drain("seq_wrap");
    endtask

    task automatic test_reset_mid_frame();
        m_ready = 1'b0;
        push_rec(3'd4, 8'h10, 8'h20, 8'h10);
        push_rec(3'd5, 8'h11, 8'h21, 8'h10);
        push_rec(3'd6, 8'h12, 8'h22, 8'h10);
        wait_m_valid("rst_mid");
        m_ready = 1'b1;
        idle(3);
        m_ready = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd2) $display("FAIL rst_mid_queued: got level=%0d, expected 2", fifo_level);
        else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 8'h00 || fifo_level !== 3'd0)
            $display("FAIL rst_mid_async: got valid=%b last=%b data=%h level=%0d, expected 0 0 00 0",
                     m_valid, m_last, m_data, fifo_level);
        else n_pass++;
        exp_q.delete();
        exp_seq = 8'd0;
        idle(2);
        #1 rst_n = 1'b1;
        idle(1);
        m_ready = 1'b1;
        push_rec(3'd1, 8'h21, 8'h22, 8'h01);
        drain("rst_mid");
    endtask

    task automatic test_ts12();
        int  waited;
        bit  ok;
        int  c;
        m12_ready = 1'b1;
        waited = 0;
        ok = 1'b0;
        in12_valid = 1'b1;
        in12_id = 3'd5;
        in12_start_ts = 12'hABC;
        in12_end_ts = 12'hABF;
        in12_delta = 12'h003;
        while (!ok && waited < 50) begin
            @(negedge clk);
            ok = in12_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        in12_valid = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL ts12_push: got in_ready=0, expected acceptance");
        else n_pass++;
        exp12_q.push_back({1'b0, 8'hA5});
        exp12_q.push_back({1'b0, 8'h00});
        exp12_q.push_back({1'b0, 8'h05});
        exp12_q.push_back({1'b0, 8'h0A});
        exp12_q.push_back({1'b0, 8'hBC});
        exp12_q.push_back({1'b0, 8'h0A});
        exp12_q.push_back({1'b0, 8'hBF});
        exp12_q.push_back({1'b0, 8'h00});
        exp12_q.push_back({1'b1, 8'h03});
        c = 0;
        while (exp12_q.size() != 0 && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        n_checks++;
        if (exp12_q.size() != 0) $display("FAIL ts12_drain: got %0d bytes pending, expected 0", exp12_q.size());
        else n_pass++;
        idle(8);
    endtask

    initial begin
        in_valid = 1'b0;
        in_id = '0;
        in_start_ts = '0;
        in_end_ts = '0;
        in_delta = '0;
        m_ready = 1'b1;
        in12_valid = 1'b0;
        in12_id = '0;
        in12_start_ts = '0;
        in12_end_ts = '0;
        in12_delta = '0;
        m12_ready = 1'b1;
        exp_seq = 8'd0;

        test_reset();
        test_single();
        test_wrap_delta();
        test_backpressure();
        test_full_back_to_back();
        test_seq_wrap();
        test_reset_mid_frame();
        test_ts12();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
